pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: tracks EXE/MEM/WB destination records, produces
// stall/flush/forward controls, and gates the core through a debug step FSM.
module pipe_ctrl #(
    parameter int ADDR_W = 5,
    parameter int STEP_W = 8,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [STEP_W-1:0] debug_cnt,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wb_wen,
    input  logic [ADDR_W-1:0] id_wb_addr,
    input  logic              id_mem_ren,
    input  logic              exe_branch_taken,
    output logic              if_en,
    output logic              id_en,
    output logic              id_flush,
    output logic              exe_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              cpu_en,
    output logic              cpu_rst,
    output logic              step_busy
);

    typedef enum logic [1:0] {
        RUN_FREE = 2'd0,
        HALT     = 2'd1,
        STEP     = 2'd2
    } dbg_state_e;

    dbg_state_e        state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              step_prev_q, step_prev_d;

    logic              exe_wen_q, exe_wen_d;
    logic [ADDR_W-1:0] exe_addr_q, exe_addr_d;
    logic              exe_mem_ren_q, exe_mem_ren_d;
    logic [ADDR_W-1:0] exe_rs_q, exe_rs_d;
    logic [ADDR_W-1:0] exe_rt_q, exe_rt_d;
    logic              exe_rs_used_q, exe_rs_used_d;
    logic              exe_rt_used_q, exe_rt_used_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_mem_ren_q, mem_mem_ren_d;
    logic              wb_wen_q, wb_wen_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic              wb_mem_ren_q, wb_mem_ren_d;

    logic step_rise;
    logic exe_hit;
    logic mem_hit;
    logic hazard;

    // A write to $0 never creates a dependency.
    function automatic logic match(input logic wen, input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] src, input logic used);
        return wen && used && (addr == src) && (addr != '0);
    endfunction

    assign cpu_rst   = rst;
    assign cpu_en    = rst || (state_q != HALT);
    assign step_busy = !rst && (state_q == STEP);
    assign step_rise = debug_step && !step_prev_q;

    always_comb begin
        exe_hit = match(exe_wen_q, exe_addr_q, id_rs, id_rs_used) ||
                  match(exe_wen_q, exe_addr_q, id_rt, id_rt_used);
        mem_hit = match(mem_wen_q, mem_addr_q, id_rs, id_rs_used) ||
                  match(mem_wen_q, mem_addr_q, id_rt, id_rt_used);
        if (FWD_EN != 0) begin
            hazard = exe_mem_ren_q && exe_hit;
        end else begin
            hazard = exe_hit || mem_hit;
        end
    end

    always_comb begin
        if_en     = 1'b1;
        id_en     = 1'b1;
        id_flush  = 1'b0;
        exe_flush = 1'b0;
        stall     = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        if (!rst) begin
            stall = hazard && !exe_branch_taken;
            if (FWD_EN != 0) begin
                if (match(mem_wen_q, mem_addr_q, exe_rs_q, exe_rs_used_q) && !mem_mem_ren_q) begin
                    fwd_a = 2'b01;
                end else if (match(wb_wen_q, wb_addr_q, exe_rs_q, exe_rs_used_q)) begin
                    fwd_a = 2'b10;
                end
                if (match(mem_wen_q, mem_addr_q, exe_rt_q, exe_rt_used_q) && !mem_mem_ren_q) begin
                    fwd_b = 2'b01;
                end else if (match(wb_wen_q, wb_addr_q, exe_rt_q, exe_rt_used_q)) begin
                    fwd_b = 2'b10;
                end
            end
            if (!cpu_en) begin
                if_en = 1'b0;
                id_en = 1'b0;
            end else if (exe_branch_taken) begin
                id_flush  = 1'b1;
                exe_flush = 1'b1;
            end else if (hazard) begin
                if_en     = 1'b0;
                id_en     = 1'b0;
                exe_flush = 1'b1;
            end
        end
    end

    always_comb begin
        exe_wen_d     = exe_wen_q;
        exe_addr_d    = exe_addr_q;
        exe_mem_ren_d = exe_mem_ren_q;
        exe_rs_d      = exe_rs_q;
        exe_rt_d      = exe_rt_q;
        exe_rs_used_d = exe_rs_used_q;
        exe_rt_used_d = exe_rt_used_q;
        mem_wen_d     = mem_wen_q;
        mem_addr_d    = mem_addr_q;
        mem_mem_ren_d = mem_mem_ren_q;
        wb_wen_d      = wb_wen_q;
        wb_addr_d     = wb_addr_q;
        wb_mem_ren_d  = wb_mem_ren_q;
        if (cpu_en) begin
            if (exe_flush) begin
                exe_wen_d     = 1'b0;
                exe_addr_d    = '0;
                exe_mem_ren_d = 1'b0;
                exe_rs_d      = '0;
                exe_rt_d      = '0;
                exe_rs_used_d = 1'b0;
                exe_rt_used_d = 1'b0;
            end else begin
                exe_wen_d     = id_wb_wen;
                exe_addr_d    = id_wb_addr;
                exe_mem_ren_d = id_mem_ren;
                exe_rs_d      = id_rs;
                exe_rt_d      = id_rt;
                exe_rs_used_d = id_rs_used;
                exe_rt_used_d = id_rt_used;
            end
            mem_wen_d     = exe_wen_q;
            mem_addr_d    = exe_addr_q;
            mem_mem_ren_d = exe_mem_ren_q;
            wb_wen_d      = mem_wen_q;
            wb_addr_d     = mem_addr_q;
            wb_mem_ren_d  = mem_mem_ren_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_prev_d = debug_step;
        case (state_q)
            RUN_FREE: begin
                if (debug_en) state_d = HALT;
            end
            HALT: begin
                if (!debug_en) begin
                    state_d = RUN_FREE;
                end else if (step_rise) begin
                    state_d = STEP;
                    cnt_d   = (debug_cnt == '0) ? STEP_W'(1) : debug_cnt;
                end
            end
            STEP: begin
                if (!debug_en) begin
                    state_d = RUN_FREE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                    if (cnt_q == STEP_W'(1)) state_d = HALT;
                end
            end
            default: state_d = RUN_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN_FREE;
            cnt_q         <= '0;
            step_prev_q   <= 1'b0;
            exe_wen_q     <= 1'b0;
            exe_addr_q    <= '0;
            exe_mem_ren_q <= 1'b0;
            exe_rs_q      <= '0;
            exe_rt_q      <= '0;
            exe_rs_used_q <= 1'b0;
            exe_rt_used_q <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_mem_ren_q <= 1'b0;
            wb_wen_q      <= 1'b0;
            wb_addr_q     <= '0;
            wb_mem_ren_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_prev_q   <= step_prev_d;
            exe_wen_q     <= exe_wen_d;
            exe_addr_q    <= exe_addr_d;
            exe_mem_ren_q <= exe_mem_ren_d;
            exe_rs_q      <= exe_rs_d;
            exe_rt_q      <= exe_rt_d;
            exe_rs_used_q <= exe_rs_used_d;
            exe_rt_used_q <= exe_rt_used_d;
            mem_wen_q     <= mem_wen_d;
            mem_addr_q    <= mem_addr_d;
            mem_mem_ren_q <= mem_mem_ren_d;
            wb_wen_q      <= wb_wen_d;
            wb_addr_q     <= wb_addr_d;
            wb_mem_ren_q  <= wb_mem_ren_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one forwarding instance and one stall-only
// instance share stimulus; expected output vectors are queued per cycle.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       debug_en;
    logic       debug_step;
    logic [7:0] debug_cnt;
    logic [4:0] id_rs, id_rt, id_wb_addr;
    logic       id_rs_used, id_rt_used, id_wb_wen, id_mem_ren;
    logic       exe_branch_taken;

    logic       if_en, id_en, id_flush, exe_flush, stall, cpu_en, cpu_rst, step_busy;
    logic [1:0] fwd_a, fwd_b;
    logic       if_en0, id_en0, id_flush0, exe_flush0, stall0, cpu_en0, cpu_rst0, step_busy0;
    logic [1:0] fwd_a0, fwd_b0;

    logic [11:0] obs1, obs0;
    logic [11:0] exp_q[$];
    logic [11:0] exp0_q[$];
    string       tag_q[$];
    string       tag0_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [11:0] norm_v, rst_v, halt_v, step_v, stall_v;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(5), .STEP_W(8), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .debug_cnt(debug_cnt), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wb_wen(id_wb_wen),
        .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren),
        .exe_branch_taken(exe_branch_taken), .if_en(if_en), .id_en(id_en),
        .id_flush(id_flush), .exe_flush(exe_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .cpu_en(cpu_en), .cpu_rst(cpu_rst), .step_busy(step_busy)
    );

    pipe_ctrl #(.ADDR_W(5), .STEP_W(8), .FWD_EN(0)) dut0 (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .debug_cnt(debug_cnt), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wb_wen(id_wb_wen),
        .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren),
        .exe_branch_taken(exe_branch_taken), .if_en(if_en0), .id_en(id_en0),
        .id_flush(id_flush0), .exe_flush(exe_flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .stall(stall0), .cpu_en(cpu_en0), .cpu_rst(cpu_rst0), .step_busy(step_busy0)
    );

    assign obs1 = {if_en, id_en, id_flush, exe_flush, fwd_a, fwd_b,
                   stall, cpu_en, cpu_rst, step_busy};
    assign obs0 = {if_en0, id_en0, id_flush0, exe_flush0, fwd_a0, fwd_b0,
                   stall0, cpu_en0, cpu_rst0, step_busy0};

    // Vector layout: if_en id_en id_flush exe_flush fwd_a fwd_b stall cpu_en cpu_rst step_busy
    function automatic logic [11:0] ev(input logic ife, input logic ide, input logic idf,
                                       input logic exf, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic st, input logic ce,
                                       input logic cr, input logic sb);
        return {ife, ide, idf, exf, fa, fb, st, ce, cr, sb};
    endfunction

    task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %03h expected %03h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check_val(tag_q.pop_front(), obs1, exp_q.pop_front());
        if (exp0_q.size() > 0) check_val(tag0_q.pop_front(), obs0, exp0_q.pop_front());
    end

    task automatic set_id(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                          input logic rtu, input logic wen, input logic [4:0] wa,
                          input logic mr);
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_wb_wen  = wen;
        id_wb_addr = wa;
        id_mem_ren = mr;
    endtask

    task automatic id_nop();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // One clock: queue expectations for the selected instances, let the
    // monitor compare at the falling edge, return just after the rising edge.
    task automatic cyc(input string tag, input logic c1, input logic [11:0] e1,
                       input logic c0, input logic [11:0] e0);
        if (c1) begin
            exp_q.push_back(e1);
            tag_q.push_back(tag);
        end
        if (c0) begin
            exp0_q.push_back(e0);
            tag0_q.push_back({tag, "_nofwd"});
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        debug_en = 1'b0;
        debug_step = 1'b0;
        exe_branch_taken = 1'b0;
        id_nop();
        cyc("reset", 1'b1, rst_v, 1'b1, rst_v);
        rst = 1'b0;
    endtask

    initial begin
        norm_v  = ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_v   = ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        halt_v  = ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step_v  = ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        stall_v = ev(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        debug_cnt = 8'd0;
        rst = 1'b1;
        debug_en = 1'b0;
        debug_step = 1'b0;
        exe_branch_taken = 1'b0;
        id_nop();
        cyc("reset_hold", 1'b1, rst_v, 1'b1, rst_v);
        do_reset();

        // Load-use: lw $1 then a reader of $1 as rs.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1);
        cyc("lw_issue", 1'b1, norm_v, 1'b0, '0);
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        cyc("load_use_stall", 1'b1, stall_v, 1'b0, '0);
        cyc("load_use_release", 1'b1, norm_v, 1'b0, '0);
        id_nop();
        cyc("fwd_a_wb", 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0),
            1'b0, '0);

        // Two writers of $2, then a reader of $2 as rt: MEM wins over WB.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
        cyc("add2_a", 1'b1, norm_v, 1'b0, '0);
        cyc("add2_b", 1'b1, norm_v, 1'b0, '0);
        set_id(5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
        cyc("rt2_issue", 1'b1, norm_v, 1'b0, '0);
        id_nop();
        cyc("fwd_b_mem_prio", 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0),
            1'b0, '0);

        // Writers of $0 never forward.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        cyc("add0_a", 1'b1, norm_v, 1'b0, '0);
        cyc("add0_b", 1'b1, norm_v, 1'b0, '0);
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0);
        cyc("rd0_issue", 1'b1, norm_v, 1'b0, '0);
        id_nop();
        cyc("fwd_zero_reg", 1'b1, norm_v, 1'b0, '0);

        // Branch taken coincident with a load-use hazard.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1);
        cyc("lw1_issue", 1'b1, norm_v, 1'b0, '0);
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
        exe_branch_taken = 1'b1;
        cyc("branch_over_stall", 1'b1,
            ev(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, '0);
        exe_branch_taken = 1'b0;
        id_nop();
        cyc("after_branch", 1'b1, norm_v, 1'b0, '0);

        // Stall-only interlock versus forwarding on the same stream.
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        cyc("add3_issue", 1'b1, norm_v, 1'b1, norm_v);
        id_nop();
        cyc("add3_gap", 1'b1, norm_v, 1'b1, norm_v);
        set_id(5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        cyc("mem_dep", 1'b1, norm_v, 1'b1, stall_v);
        cyc("wb_dep", 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0),
            1'b1, norm_v);
        set_id(5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        cyc("exe_dep", 1'b1, norm_v, 1'b1, stall_v);

        // Debug stepping: 3-cycle step with an ignored mid-step pulse, then N=0.
        do_reset();
        debug_en = 1'b1;
        debug_cnt = 8'd3;
        cyc("dbg_run", 1'b1, norm_v, 1'b0, '0);
        debug_step = 1'b1;
        cyc("dbg_halt", 1'b1, halt_v, 1'b0, '0);
        debug_step = 1'b0;
        cyc("step3_c1", 1'b1, step_v, 1'b0, '0);
        debug_step = 1'b1;
        cyc("step3_c2", 1'b1, step_v, 1'b0, '0);
        debug_step = 1'b0;
        cyc("step3_c3", 1'b1, step_v, 1'b0, '0);
        cyc("step3_done", 1'b1, halt_v, 1'b0, '0);
        debug_cnt = 8'd0;
        debug_step = 1'b1;
        cyc("step0_req", 1'b1, halt_v, 1'b0, '0);
        cyc("step0_c1", 1'b1, step_v, 1'b0, '0);
        cyc("step0_done", 1'b1, halt_v, 1'b0, '0);
        debug_step = 1'b0;
        cyc("step0_idle", 1'b1, halt_v, 1'b0, '0);

        // Reset during a step, then hazard visibility while halted.
        debug_cnt = 8'd5;
        debug_step = 1'b1;
        cyc("step5_req", 1'b1, halt_v, 1'b0, '0);
        debug_step = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1);
        cyc("step5_c1", 1'b1, step_v, 1'b0, '0);
        rst = 1'b1;
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc("rst_mid_step", 1'b1, rst_v, 1'b0, '0);
        rst = 1'b0;
        cyc("rst_release", 1'b1, norm_v, 1'b0, '0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
        debug_cnt = 8'd1;
        debug_step = 1'b1;
        cyc("rehalt", 1'b1, halt_v, 1'b0, '0);
        debug_step = 1'b0;
        cyc("step1_lw2", 1'b1, step_v, 1'b0, '0);
        set_id(5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
        cyc("halt_hazard", 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0),
            1'b0, '0);
        debug_en = 1'b0;
        cyc("halt_exit", 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0),
            1'b0, '0);
        cyc("resume_stall", 1'b1, stall_v, 1'b0, '0);
        cyc("resume_clear", 1'b1, norm_v, 1'b0, '0);

        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", exp_q.size(), exp0_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
